// File: rtl/gaplus_starfield.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : gaplus_starfield                                              |
// | Brief    : Gaplus starfield - CPU control registers, three scrolling    |
// |            hashed star layers and a two-stage pixel pipeline.            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module gaplus_starfield #(
    parameter int SCRL_W    = 13,
    parameter int DENS_BITS = 6
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       PCLK_EN,
    input  logic [8:0] HPOS,
    input  logic [8:0] VPOS,
    input  logic       HBLK,
    input  logic       VBLK,
    input  logic [1:0] CPU_AD,
    input  logic [7:0] CPU_DT,
    input  logic       CPU_WE,
    output logic [5:0] STAR_COL,
    output logic       STAR_EN
);

    localparam int          C_LAYERS   = 3;
    localparam logic [15:0] C_HASH_MUL = 16'd40503;

    logic                cpu_we_q;
    logic                vblk_q;
    logic [7:0]          ctrl_q [4];
    logic [7:0]          vpos_q;
    logic                blank_q;
    logic                en_q;
    logic [5:0]          star_col_q;
    logic [5:0]          star_col_d;
    logic                star_en_q;
    logic                star_en_d;

    logic                w_wr;
    logic                w_tick;
    logic [C_LAYERS-1:0] w_hit;
    logic [5:0]          w_col [C_LAYERS];

    // Rising-edge detection keeps a held strobe or a long VBLK to one event.
    assign w_wr   = CPU_WE & ~cpu_we_q;
    assign w_tick = VBLK & ~vblk_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            cpu_we_q <= 1'b0;
            vblk_q   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                ctrl_q[i] <= 8'h00;
            end
        end else begin
            cpu_we_q <= CPU_WE;
            vblk_q   <= VBLK;
            if (w_wr) begin
                ctrl_q[CPU_AD] <= CPU_DT;
            end
        end
    end

    generate
        for (genvar n = 0; n < C_LAYERS; n++) begin : g_layer
            localparam logic [15:0] C_SALT = 16'(n * 32'h3C5A);

            logic [SCRL_W-1:0] scrl_q;
            logic [8:0]        x_q;
            logic [SCRL_W-1:0] w_speed;
            logic [15:0]       w_hash;
            logic              unused_hash;

            assign w_speed = {{(SCRL_W-8){ctrl_q[n+1][7]}}, ctrl_q[n+1]};

            // The tick reads ctrl_q before any same-edge write lands.
            always_ff @(posedge CLK) begin
                if (RESET) begin
                    scrl_q <= '0;
                    x_q    <= '0;
                end else begin
                    if (w_tick) begin
                        scrl_q <= scrl_q + w_speed;
                    end
                    if (PCLK_EN) begin
                        x_q <= HPOS + scrl_q[SCRL_W-1 -: 9];
                    end
                end
            end

            assign w_hash      = ({7'd0, x_q} * C_HASH_MUL) ^ {vpos_q, vpos_q} ^ C_SALT;
            assign w_hit[n]    = (w_hash[15 -: DENS_BITS] == '0);
            assign w_col[n]    = (w_hash[5:0] == 6'd0) ? 6'h3F : w_hash[5:0];
            assign unused_hash = ^w_hash;
        end
    endgenerate

    // Walk from the back layer forward so layer 0 is written last and wins.
    always_comb begin
        star_en_d  = 1'b0;
        star_col_d = 6'd0;
        if (en_q && !blank_q) begin
            for (int i = C_LAYERS - 1; i >= 0; i--) begin
                if (w_hit[i]) begin
                    star_en_d  = 1'b1;
                    star_col_d = w_col[i];
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            vpos_q     <= 8'd0;
            blank_q    <= 1'b0;
            en_q       <= 1'b0;
            star_col_q <= 6'd0;
            star_en_q  <= 1'b0;
        end else if (PCLK_EN) begin
            vpos_q     <= VPOS[7:0];
            blank_q    <= HBLK | VBLK;
            en_q       <= ctrl_q[0][0];
            star_col_q <= star_col_d;
            star_en_q  <= star_en_d;
        end
    end

    assign STAR_COL = star_col_q;
    assign STAR_EN  = star_en_q;

    logic unused_in;
    assign unused_in = ^{VPOS[8], ctrl_q[0][7:1]};

endmodule
`default_nettype wire

// File: tb/tb_gaplus_starfield.sv
`default_nettype none
// Testbench for gaplus_starfield: scoreboard of expected pixels fed by a
// behavioural model, plus direct register checks at the scenario boundaries.
module tb_gaplus_starfield;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       PCLK_EN = 1'b0;
    logic [8:0] HPOS = 9'd0;
    logic [8:0] VPOS = 9'd0;
    logic       HBLK = 1'b0;
    logic       VBLK = 1'b0;
    logic [1:0] CPU_AD = 2'd0;
    logic [7:0] CPU_DT = 8'd0;
    logic       CPU_WE = 1'b0;
    logic [5:0] STAR_COL;
    logic       STAR_EN;

    int n_checks = 0;
    int n_pass   = 0;

    int m_ctrl [4];
    int m_scrl [3];
    bit m_we_prev;
    bit m_vblk_prev;
    int exp_q [$];
    int last_exp = 0;

    always #5 CLK = ~CLK;

    gaplus_starfield dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .PCLK_EN  (PCLK_EN),
        .HPOS     (HPOS),
        .VPOS     (VPOS),
        .HBLK     (HBLK),
        .VBLK     (VBLK),
        .CPU_AD   (CPU_AD),
        .CPU_DT   (CPU_DT),
        .CPU_WE   (CPU_WE),
        .STAR_COL (STAR_COL),
        .STAR_EN  (STAR_EN)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic int hash(input int n, input int x, input int v);
        return ((x * 40503) % 65536) ^ ((v % 256) * 257) ^ ((n * 32'h3C5A) % 65536);
    endfunction

    // Expected {STAR_EN, STAR_COL} as 7-bit value, from current model state.
    function automatic int pixel(input int h, input int v, input bit hb, input bit vb);
        int x;
        int hh;
        if ((m_ctrl[0] % 2) == 0 || hb || vb) return 0;
        for (int n = 0; n < 3; n++) begin
            x  = (h + m_scrl[n] / 16) % 512;
            hh = hash(n, x, v);
            if (hh < 1024) return 64 + (((hh % 64) == 0) ? 63 : (hh % 64));
        end
        return 0;
    endfunction

    task automatic model_edge();
        int sp;
        if (RESET) begin
            for (int i = 0; i < 4; i++) m_ctrl[i] = 0;
            for (int i = 0; i < 3; i++) m_scrl[i] = 0;
            m_we_prev   = 1'b0;
            m_vblk_prev = 1'b0;
        end else begin
            if (VBLK && !m_vblk_prev) begin
                for (int n = 0; n < 3; n++) begin
                    sp = m_ctrl[n+1];
                    if (sp > 127) sp -= 256;
                    m_scrl[n] = (m_scrl[n] + sp + 8192) % 8192;
                end
            end
            if (CPU_WE && !m_we_prev) m_ctrl[int'(CPU_AD)] = int'(CPU_DT);
            m_we_prev   = CPU_WE;
            m_vblk_prev = VBLK;
        end
    endtask

    // One CLK: enqueue the expected pixel for the sampling edge, then advance the model.
    task automatic step();
        if (!RESET && PCLK_EN) exp_q.push_back(pixel(int'(HPOS), int'(VPOS), HBLK, VBLK));
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
    endtask

    // Monitor: every edge has a defined expected output (held when PCLK_EN=0).
    initial begin
        bit rs;
        bit en;
        forever begin
            @(posedge CLK);
            rs = RESET;
            en = PCLK_EN;
            #1;
            if (rs) begin
                exp_q.delete();
                last_exp = 0;
            end else if (en && exp_q.size() >= 2) begin
                last_exp = exp_q.pop_front();
            end
            check("pixel", int'({STAR_EN, STAR_COL}), last_exp);
        end
    end

    task automatic do_reset();
        RESET  = 1'b1;
        CPU_WE = 1'b0;
        VBLK   = 1'b0;
        step();
        step();
        RESET = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d, input int hold);
        CPU_AD = a;
        CPU_DT = d;
        CPU_WE = 1'b1;
        for (int i = 0; i < hold; i++) begin
            step();
            CPU_DT = ~d;
        end
        CPU_WE = 1'b0;
        step();
    endtask

    task automatic tick();
        VBLK = 1'b1;
        step();
        VBLK = 1'b0;
        step();
    endtask

    task automatic sweep(input int v, input int h0, input int h1);
        PCLK_EN = 1'b1;
        VPOS    = 9'(v);
        for (int h = h0; h <= h1; h++) begin
            HPOS = 9'(h);
            step();
        end
    endtask

    task automatic regs_check(input string tag);
        for (int i = 0; i < 4; i++) check({tag, "_ctrl"}, int'(dut.ctrl_q[i]), m_ctrl[i]);
        check({tag, "_scrl0"}, int'(dut.g_layer[0].scrl_q), m_scrl[0]);
        check({tag, "_scrl1"}, int'(dut.g_layer[1].scrl_q), m_scrl[1]);
        check({tag, "_scrl2"}, int'(dut.g_layer[2].scrl_q), m_scrl[2]);
    endtask

    initial begin
        int cx = -1;
        int cv = 0;
        int zx = -1;
        int zv = 0;
        int h0;

        @(negedge CLK);
        do_reset();
        regs_check("reset");

        // Held strobe with changing data: only the first value may land.
        wr(2'd0, 8'h01, 5);
        check("ctrl0_once", int'(dut.ctrl_q[0]), 8'h01);
        regs_check("wr_hold");

        wr(2'd1, 8'h10, 1);
        repeat (3) tick();
        check("scrl0_3px", int'(dut.g_layer[0].scrl_q), 'h030);
        sweep(0, 0, 511);
        sweep(37, 0, 255);

        do_reset();
        wr(2'd0, 8'h01, 1);
        wr(2'd1, 8'hF0, 1);
        tick();
        check("scrl0_wrap", int'(dut.g_layer[0].scrl_q), 'h1FF0);

        // Write CTRL2 on the very edge of a frame tick.
        wr(2'd2, 8'h04, 1);
        CPU_AD = 2'd2;
        CPU_DT = 8'h20;
        CPU_WE = 1'b1;
        VBLK   = 1'b1;
        step();
        CPU_WE = 1'b0;
        VBLK   = 1'b0;
        step();
        check("scrl1_same_edge", int'(dut.g_layer[1].scrl_q), 'h004);
        tick();
        check("scrl1_next_tick", int'(dut.g_layer[1].scrl_q), 'h024);
        regs_check("same_edge");

        do_reset();
        wr(2'd0, 8'h01, 1);
        sweep(0, 0, 511);

        for (int v = 0; v < 256; v++) begin
            for (int x = 0; x < 512; x++) begin
                h0 = hash(0, x, v);
                if (h0 < 1024) begin
                    if (cx < 0 && hash(1, x, v) < 1024) begin cx = x; cv = v; end
                    if (zx < 0 && (h0 % 64) == 0) begin zx = x; zv = v; end
                end
            end
        end
        if (zx >= 0) begin sweep(zv, zx, zx); sweep(zv, zx, zx); end
        if (cx >= 0) begin sweep(cv, cx, cx); sweep(cv, cx, cx); end

        wr(2'd0, 8'h00, 1);
        sweep(5, 100, 163);
        wr(2'd0, 8'h01, 1);
        HBLK = 1'b1;
        sweep(5, 100, 163);
        HBLK = 1'b0;
        sweep(5, 164, 200);

        // Star into the pipeline, then freeze the pixel clock.
        if (cx >= 0) begin
            sweep(cv, cx, cx);
            sweep(cv, cx + 1, cx + 1);
        end
        PCLK_EN = 1'b0;
        for (int i = 0; i < 4; i++) begin
            HPOS = 9'($urandom_range(511));
            step();
        end

        sweep(0, 0, 200);
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        check("midrst_ctrl0", int'(dut.ctrl_q[0]), 0);
        check("midrst_scrl0", int'(dut.g_layer[0].scrl_q), 0);
        regs_check("midrst");
        sweep(0, 201, 511);

        wr(2'd0, 8'h01, 1);
        for (int i = 0; i < 3000; i++) begin
            PCLK_EN = ($urandom_range(3) != 0);
            HPOS    = 9'($urandom_range(511));
            VPOS    = 9'($urandom_range(511));
            HBLK    = ($urandom_range(9) == 0);
            if ($urandom_range(39) == 0) VBLK = ~VBLK;
            if (!CPU_WE && $urandom_range(29) == 0) begin
                CPU_WE = 1'b1;
                CPU_AD = 2'($urandom_range(3));
                CPU_DT = 8'($urandom_range(255));
                if (CPU_AD == 2'd0 && $urandom_range(3) != 0) CPU_DT[0] = 1'b1;
            end else if (CPU_WE && $urandom_range(2) == 0) begin
                CPU_WE = 1'b0;
            end else if (CPU_WE) begin
                CPU_DT = 8'($urandom_range(255));
            end
            RESET = ($urandom_range(799) == 0);
            if (RESET) begin
                CPU_WE = 1'b0;
                VBLK   = 1'b0;
            end
            step();
        end
        RESET  = 1'b0;
        CPU_WE = 1'b0;
        VBLK   = 1'b0;
        HBLK   = 1'b0;
        step();
        regs_check("final");
        PCLK_EN = 1'b1;
        repeat (4) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
